// File: rtl/piso16_tx.sv
// piso16_tx -- parallel-in/serial-out transmitter.
//
// Captures a WIDTH-bit word on a load/in_ready handshake. It then shifts the
// word out one bit per accepted beat on a sout/sout_valid/out_ready serial
// interface. done pulses for one cycle after the final beat of each frame.
//
// Optional feature (macro PISO_PARITY_EN): when defined, an even-parity beat
// (XOR of the captured word) follows the data bits. A frame is then WIDTH+1
// beats long.
//
// Parameters:
//   WIDTH      data word width in bits (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   load        request to capture vecin (honoured only while in_ready=1)
//   vecin       parallel word to transmit
//   in_ready    high while idle; a load will be accepted
//   sout        current serial bit
//   sout_valid  sout holds a valid bit
//   out_ready   sink accepts sout this cycle
//   done        one-cycle pulse after the last beat of a frame is accepted
//   busy        high while a frame is in progress
module piso16_tx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] vecin,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             busy
);

  // One extra bit so the counter reaches WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt_reg;
  logic             data_bit;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  // Shift toward the output end with zero fill. After a full frame, the
  // register is all zeros again.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign data_bit = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];

  // sout is a pure select of registered state. It is forced low when idle.
`ifdef PISO_PARITY_EN
  assign sout = (state_reg == SHIFT)  ? data_bit   :
                (state_reg == PARITY) ? parity_reg : 1'b0;
`else
  assign sout = (state_reg == SHIFT) ? data_bit : 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            shreg_reg  <= vecin;
            cnt_reg    <= '0;
            state_reg  <= SHIFT;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
`ifdef PISO_PARITY_EN
            // Parity is taken from the word as captured, not from later vecin.
            parity_reg <= ^vecin;
`endif
          end
        end
        SHIFT: begin
          // sout_valid is always high here, so out_ready alone accepts a beat.
          if (out_ready) begin
            shreg_reg <= shreg_shifted;
            cnt_reg   <= cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
`ifdef PISO_PARITY_EN
              state_reg  <= PARITY;
`else
              state_reg  <= IDLE;
              sout_valid <= 1'b0;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              done       <= 1'b1;
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (out_ready) begin
            state_reg  <= IDLE;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            done       <= 1'b1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso16_tx.sv
// tb_piso16_tx -- scoreboard bench for piso16_tx.
//
// A model process watches the inputs on each rising edge. When a load is
// accepted, it pushes the expected beat sequence into a queue, derived
// directly from the word and the bit-order rule. A monitor on the falling
// edge compares the DUT outputs against the head of that queue and against
// the expected done pulse. The driver issues directed frames and then a
// randomized phase.
module tb_piso16_tx;

  localparam int WIDTH     = 16;
  localparam bit MSB_FIRST = 1'b1;
`ifdef PISO_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] vecin;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             out_ready;
  logic             done;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  // Each entry: {last_beat_of_frame, expected_bit}
  logic [1:0] exp_q[$];
  logic       done_exp = 1'b0;
  logic [1:0] ent;

  piso16_tx #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst(rst), .load(load), .vecin(vecin), .in_ready(in_ready),
    .sout(sout), .sout_valid(sout_valid), .out_ready(out_ready),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted load enqueues the whole frame.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        done_exp = 1'b0;
      end else begin
        done_exp = 1'b0;
        if (exp_q.size() > 0) begin
          if (out_ready) begin
            ent = exp_q.pop_front();
            if (ent[1]) done_exp = 1'b1;
          end
        end else if (load) begin
          for (int i = 0; i < WIDTH; i++) begin
            logic b;
            b = MSB_FIRST ? vecin[WIDTH-1-i] : vecin[i];
            exp_q.push_back({(i == BEATS - 1), b});
          end
`ifdef PISO_PARITY_EN
          exp_q.push_back({1'b1, ($countones(vecin) % 2) == 1});
`endif
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check("sout_valid", 32'(sout_valid), 32'd1);
        check("busy", 32'(busy), 32'd1);
        check("in_ready", 32'(in_ready), 32'd0);
        check("sout", 32'(sout), 32'(exp_q[0][0]));
      end else begin
        check("sout_valid_idle", 32'(sout_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        check("sout_idle", 32'(sout), 32'd0);
      end
      check("done", 32'(done), 32'(done_exp));
      if (done === 1'b1) $display("frame complete t=%0t", $time);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Send one word. The stall window and the injected load are cycle indices
  // counted from the first bit cycle (cycle 1). Checks the cycle index at
  // which done appears.
  task automatic send(input logic [WIDTH-1:0] w, input int stall_c, input int stall_n,
                      input int inj_c, input string nm);
    int guard;
    int cyc;
    guard = 0;
    out_ready = 1'b1;
    while (in_ready !== 1'b1 && guard < 200) begin
      tick;
      guard++;
    end
    check({nm, "_ready"}, 32'(in_ready), 32'd1);
    load = 1'b1;
    vecin = w;
    tick;
    load = 1'b0;
    vecin = WIDTH'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      out_ready = !(cyc >= stall_c && cyc < stall_c + stall_n);
      load = (cyc == inj_c);
      if (load) vecin = '1;
      tick;
      cyc++;
    end
    load = 1'b0;
    out_ready = 1'b1;
    check({nm, "_latency"}, 32'(cyc), 32'(BEATS + 1 + stall_n));
    $display("sent %s word=%04h done_cycle=%0d", nm, w, cyc);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    vecin = '0;
    out_ready = 1'b0;
    tick;
    tick;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick;

    send(16'h000F, 0, 0, 0, "basic");
    send(16'hA5C3, 6, 3, 0, "stall");
    send(16'h5A3C, 0, 0, 4, "ignored_load");
    tick;
    tick;
    check("no_second_frame", 32'(busy), 32'd0);

    // Reset mid-frame after 7 accepted bits.
    out_ready = 1'b1;
    load = 1'b1;
    vecin = 16'h1234;
    tick;
    load = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sout", 32'(sout), 32'd0);
    check("midrst_valid", 32'(sout_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    send(16'h0001, 0, 0, 0, "after_reset");

`ifdef PISO_PARITY_EN
    send(16'h0007, 0, 0, 0, "parity_odd");
    send(16'h0003, 0, 0, 0, "parity_even");
`endif

    // Randomized phase: random loads (many while busy), random backpressure.
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 2) == 0);
      vecin = WIDTH'($urandom);
      tick;
    end
    load = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < BEATS + 4; i++) tick;
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
